// File: rtl/mem_lsu.sv
// MEM-stage load/store unit for a word-wide data memory without byte enables.
// Sub-word stores use a read-modify-write; misaligned/out-of-range accesses are flagged.
module mem_lsu #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic                req_err_c;
  logic [4:0]          sh_c;
  logic [31:0]         lane_c;
  logic [31:0]         load_ext_c;
  logic [31:0]         lane_mask_c;
  logic [31:0]         merged_c;

  // Illegal size, misalignment, or address beyond the memory's word range
  always_comb begin
    req_err_c = (req_size == SZ_X)
              | ((req_size == SZ_H) & req_addr[0])
              | ((req_size == SZ_W) & (|req_addr[1:0]))
              | (|(req_addr >> (ADDR_W + 2)));
  end

  // Little-endian lane extraction and read-modify-write merge
  always_comb begin
    sh_c        = {off_q, 3'b000};
    lane_c      = mem_rdata >> sh_c;
    lane_mask_c = ((size_q == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF) << sh_c;
    merged_c    = (mem_rdata & ~lane_mask_c) | ((wdata_q << sh_c) & lane_mask_c);
    case (size_q)
      SZ_B:    load_ext_c = {{24{sgn_q & lane_c[7]}}, lane_c[7:0]};
      SZ_H:    load_ext_c = {{16{sgn_q & lane_c[15]}}, lane_c[15:0]};
      default: load_ext_c = lane_c;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    off_d        = off_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    we_d         = we_q;
    err_d        = err_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[ADDR_W+1:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          sgn_d   = req_signed;
          we_d    = req_we;
          err_d   = req_err_c;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (err_q) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end else if (!we_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext_c;
          state_d      = IDLE;
        end else if (size_q == SZ_W) begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          wdata_d = merged_c;
          state_d = WRITE;
        end
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      we_q         <= we_d;
      err_q        <= err_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Write strobe is gated by reset so an aborted WRITE never reaches memory
  always_comb begin
    mem_wr = !rst && (((state_q == ACCESS) && we_q && !err_q && (size_q == SZ_W))
                      || (state_q == WRITE));
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_raddr  = idx_q;
  assign mem_waddr  = idx_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: behavioural memory, reference memory model,
// and a response scoreboard compared whenever resp_valid fires.
module tb_mem_lsu;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_wr) mem[mem_waddr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response is compared against the oldest expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // Issue one request, model it, and check write activity and response latency
  task automatic op(input logic we, input logic [1:0] size, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    logic [6:0]  idx;
    logic [31:0] old, lane, exp_rd, new_w, m;
    int          exp_lat, lat, nwr, wr_lat;
    idx = addr[8:2];
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:9] != 23'd0);
    old    = err ? 32'h0 : ref_mem[idx];
    lane   = old >> (8 * addr[1:0]);
    exp_rd = 32'h0;
    new_w  = old;
    if (!err && !we) begin
      if (size == 2'b00)      exp_rd = {{24{sgn & lane[7]}}, lane[7:0]};
      else if (size == 2'b01) exp_rd = {{16{sgn & lane[15]}}, lane[15:0]};
      else                    exp_rd = old;
    end
    if (!err && we) begin
      if (size == 2'b10) new_w = wdata;
      else begin
        m     = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * addr[1:0]);
        new_w = (old & ~m) | ((wdata << (8 * addr[1:0])) & m);
      end
    end
    exp_lat = (!err && we && size != 2'b10) ? 3 : 2;
    sb_q.push_back('{err: err, rdata: exp_rd});

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; nwr = 0; wr_lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_wr) begin
        nwr++;
        wr_lat = i;
        check("mem_waddr", 32'(mem_waddr), 32'(idx));
        check("mem_wdata", mem_wdata, new_w);
      end
      if (resp_valid) begin
        lat = i;
        check("ready_with_resp", 32'(req_ready), 32'd1);
        break;
      end
    end
    check("resp_latency", 32'(lat), 32'(exp_lat));
    check("write_count", 32'(nwr), (!err && we) ? 32'd1 : 32'd0);
    if (!err && we) check("write_cycle", 32'(wr_lat), 32'(exp_lat - 1));
    if (!err && we) ref_mem[idx] = new_w;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h50; req_wdata = 32'hCAFE_F00D;

    // Reset held with a pending request
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
    end
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store then load
    op(1'b1, 2'b10, 1'b0, 32'h50, 32'hDEAD_BEEF);
    op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);

    // Byte read-modify-write and byte loads
    op(1'b1, 2'b10, 1'b0, 32'h50, 32'h1122_3344);
    op(1'b1, 2'b00, 1'b0, 32'h51, 32'h0000_00A5);
    op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    op(1'b0, 2'b00, 1'b1, 32'h51, 32'h0);
    op(1'b0, 2'b00, 1'b0, 32'h51, 32'h0);
    check("sb_merged_word", mem[20], 32'h1122_A544);

    // Halfword loads and store
    op(1'b1, 2'b10, 1'b0, 32'h50, 32'h8001_0000);
    op(1'b0, 2'b01, 1'b1, 32'h52, 32'h0);
    op(1'b0, 2'b01, 1'b0, 32'h52, 32'h0);
    op(1'b1, 2'b01, 1'b0, 32'h50, 32'hFFFF_7777);
    op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    op(1'b0, 2'b00, 1'b1, 32'h53, 32'h0);
    check("sh_merged_word", mem[20], 32'h8001_7777);

    // Illegal accesses
    op(1'b0, 2'b10, 1'b0, 32'h52, 32'h0);
    op(1'b0, 2'b01, 1'b1, 32'h51, 32'h0);
    op(1'b0, 2'b11, 1'b0, 32'h50, 32'h0);
    op(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678);
    check("err_store_no_write", mem[0], 32'h0);

    // Reset pulsed while the byte store sits in WRITE
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h0000_00FF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_access_no_wr", 32'(mem_wr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_write_no_wr", 32'(mem_wr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_word_kept", mem[20], 32'h8001_7777);
    op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit sitting in the MEM stage between the pipeline and the word-wide data memory (7-bit word address, 32-bit data, combinational read, write on clock edge when write-enable is high). It accepts byte/halfword/word load and store requests on byte addresses and drives the memory's read address, write address, write enable and write data. It returns aligned, sign- or zero-extended load data and flags illegal accesses. Sub-word stores use a read-modify-write sequence because the memory has no byte enables.

## Interface
- ADDR_W, 7, word-address width of the data memory (2^ADDR_W words)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present; the pipeline holds it until accepted
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word stores
- resp_valid  out  1  one-cycle pulse: load data valid, store complete, or error
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: access rejected
- mem_raddr  out  ADDR_W  memory read word address
- mem_waddr  out  ADDR_W  memory write word address
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_raddr

## Operation
- States: IDLE, ACCESS, WRITE. req_ready = (state == IDLE).
- On accept, register: word index = req_addr[ADDR_W+1:2], byte offset = req_addr[1:0], size, signed, we, wdata, and an error flag. Then go to ACCESS.
- The error flag is set for any of these: size 11; halfword with addr[0] = 1; word with addr[1:0] != 0; req_addr[31:ADDR_W+2] != 0 (out of range).
- Byte lanes are little-endian. Offset k selects bits 8k+7:8k. A halfword at offset 0 uses bits 15:0; at offset 2 it uses bits 31:16.
- ACCESS with error: no memory write. Load resp_valid=1, resp_err=1, resp_rdata=0. Return to IDLE.
- ACCESS, load: sample mem_rdata, extract the lane, extend per signed, load into resp_rdata. Set resp_valid. Return to IDLE.
- ACCESS, word store: mem_wr=1, mem_wdata = stored wdata. Set resp_valid. Return to IDLE.
- ACCESS, sub-word store: sample mem_rdata and replace the addressed lane with wdata[7:0] or wdata[15:0]. Register the merged word into mem_wdata. Go to WRITE.
- WRITE: mem_wr=1 with the merged word. Set resp_valid. Return to IDLE.
- mem_raddr = mem_waddr = the registered word index at all times. mem_wr is 1 only in the store cycles above, and is forced to 0 whenever rst = 1.
- resp_valid, resp_err and resp_rdata are registered. They hold for exactly one cycle and then clear to 0.
- A request presented while req_ready = 0 is ignored. It is not queued.

## Timing
- Request accepted at cycle T.
- Load: memory read during T+1; resp_valid in T+2.
- Word store: write at the end of T+1; resp_valid in T+2.
- Sub-word store: read during T+1, write at the end of T+2; resp_valid in T+3.
- Error: resp_valid and resp_err in T+2; no write.
- Throughput: req_ready returns in the same cycle resp_valid is high, so a new request can be accepted in T+2 (T+3 for a sub-word store). Back-to-back loads sustain one per 2 cycles.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, mem_raddr/mem_waddr 0, mem_wdata 0, mem_wr 0.
- Reset mid-operation: rst in any cycle aborts the operation. No write occurs in that cycle, even in WRITE. No response is produced, and the next state is IDLE.

## Test plan
- Reset: hold rst 2 cycles with req_valid=1 -> all outputs at their reset values, no mem_wr. After release, req_ready=1.
- Word store then load: sw 0xDEADBEEF to 0x50 -> mem_wr=1, mem_waddr=20 in T+1, resp_valid in T+2. Then lw 0x50 -> resp_rdata=0xDEADBEEF, resp_err=0 in T+2.
- Byte RMW: word 20 = 0x11223344; sb 0xA5 to 0x51 -> no write in T+1, mem_wr=1 with mem_wdata=0x1122A544 in T+2, resp_valid in T+3. Then lb (signed) 0x51 -> 0xFFFFFFA5; lbu -> 0x000000A5.
- Halfword: word 20 = 0x80010000; lh 0x52 -> 0xFFFF8001; lhu 0x52 -> 0x00008001. sh 0x7777 to 0x50 -> word becomes 0x80017777.
- Errors: lw 0x52, lh 0x51, size 11, and sw 0x200 (word 128) -> each gives resp_valid=1, resp_err=1, resp_rdata=0 in T+2, with mem_wr never asserted.
- Reset in WRITE: sb 0xFF to 0x50 with rst pulsed in T+2 -> no mem_wr, word 20 unchanged, no resp_valid, req_ready=1 in T+3.
